// File: rtl/sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
//   state_e  : sequencer states
//   VEC_W    : width of the input-vector index
//   NUM_VEC  : number of input vectors swept
//   LAST_VEC : index of the final vector; leaving it ends the sweep
package sweeper_pkg;

  localparam int unsigned VEC_W   = 3;
  localparam int unsigned NUM_VEC = 8;
  localparam logic [VEC_W-1:0] LAST_VEC = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

endpackage

// File: rtl/settle_timer.sv
// Settle-time counter for one applied input vector.
//   clk, reset : clock and synchronous active-high reset
//   clr_i      : force the count to zero (wins over en_i)
//   en_i       : advance the count by one
//   tc_o       : count has reached SETTLE_CYCLES-1
module settle_timer #(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end
  if (CNT_W < 32 && (SETTLE_CYCLES - 1) >= (32'd1 << CNT_W)) begin : g_bad_width
    $error("CNT_W too narrow for SETTLE_CYCLES-1");
  end

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LastCnt);

endmodule

// File: rtl/truth_table_sweeper.sv
// Characterises a 3-input, 1-output gate: applies vectors 000..111, holds each for
// SETTLE_CYCLES cycles, samples gate_out once, then compares against TRUTH_TABLE.
//   clk, reset    : clock and synchronous active-high reset
//   start         : begin a sweep (honoured only while idle)
//   abort         : abandon a running sweep without a done pulse
//   gate_out      : gate-under-test output, synchronous to clk
//   in1..in3      : gate inputs, in1 is the MSB of the vector index
//   busy          : sweep in progress
//   done          : one-cycle pulse when a sweep completes
//   pass          : observed matches TRUTH_TABLE (valid from done)
//   observed      : captured response, bit i for vector i
//   mismatch      : observed ^ TRUTH_TABLE (valid from done)
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter logic [7:0]  TRUTH_TABLE   = 8'hE9,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] observed,
  output logic [7:0] mismatch
);

  state_e           state_d, state_q;
  logic [VEC_W-1:0] vec_d, vec_q;
  logic [7:0]       obs_d, obs_q;
  logic [7:0]       mis_d, mis_q;
  logic             pass_d, pass_q;
  logic             tc;
  logic             tmr_clr;
  logic             tmr_en;

  // Count only while settling; restart from zero for every new vector.
  assign tmr_en  = (state_q == StSettle);
  assign tmr_clr = (state_q != StSettle) || tc || abort;

  settle_timer #(
    .CNT_W        (CNT_W),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk  (clk),
    .reset(reset),
    .clr_i(tmr_clr),
    .en_i (tmr_en),
    .tc_o (tc)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    obs_d   = obs_q;
    mis_d   = mis_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSettle;
          vec_d   = '0;
          obs_d   = '0;
          mis_d   = '0;
          pass_d  = 1'b0;
        end
      end
      StSettle: begin
        if (abort) begin
          state_d = StIdle;
          mis_d   = '0;
          pass_d  = 1'b0;
        end else if (tc) begin
          state_d = StSample;
        end
      end
      StSample: begin
        if (abort) begin
          state_d = StIdle;
          mis_d   = '0;
          pass_d  = 1'b0;
        end else begin
          obs_d[vec_q] = gate_out;
          if (vec_q == LAST_VEC) begin
            // Verdict uses the response including the bit captured this cycle.
            state_d = StDone;
            mis_d   = obs_d ^ TRUTH_TABLE;
            pass_d  = (obs_d == TRUTH_TABLE);
          end else begin
            state_d = StSettle;
            vec_d   = vec_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      vec_q   <= '0;
      obs_q   <= '0;
      mis_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      obs_q   <= obs_d;
      mis_q   <= mis_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    {in1, in2, in3} = 3'b000;
    if (state_q != StIdle) begin
      {in1, in2, in3} = vec_q;
    end
  end

  assign busy     = (state_q == StSettle) || (state_q == StSample);
  assign done     = (state_q == StDone);
  assign pass     = pass_q;
  assign observed = obs_q;
  assign mismatch = mis_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with a behavioural gate model (rule 0xE9).
module tb_truth_table_sweeper;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic       gate_out;
  logic       in1, in2, in3;
  logic       busy, done, pass;
  logic [7:0] observed, mismatch;

  int n_cmp;
  int n_mis;

  // 0: correct gate, 1: output stuck at 0, 2: vector 3 inverted
  int         gate_mode;
  logic [7:0] gate_tt;
  logic [2:0] gate_vec;

  truth_table_sweeper #(
    .TRUTH_TABLE  (8'hE9),
    .SETTLE_CYCLES(4),
    .CNT_W        (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .gate_out(gate_out),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .observed(observed),
    .mismatch(mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    gate_tt  = 8'hE9;
    gate_vec = {in1, in2, in3};
    gate_out = gate_tt[gate_vec];
    if (gate_mode == 1) gate_out = 1'b0;
    if (gate_mode == 2 && gate_vec == 3'd3) gate_out = ~gate_tt[gate_vec];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after the edge that accepts start (cycle 0). Watches ncyc cycles,
  // sampling at the negedge, and tallies input-sequence and busy errors.
  task automatic watch(input bit repulse, input int ncyc, output int done_cyc,
                       output int done_cnt, output int seq_err);
    int exp_vec;
    done_cyc = 0;
    done_cnt = 0;
    seq_err  = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start   = repulse && (c == 10 || c == 20);
      exp_vec = (c <= 40) ? (c - 1) / 5 : 0;
      if (c != 41 && {in1, in2, in3} != exp_vec[2:0]) seq_err++;
      if (busy != (c <= 40)) seq_err++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
    end
    start = 1'b0;
  endtask

  task automatic kick_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
  endtask

  int d_cyc, d_cnt, s_err;

  initial begin
    n_cmp     = 0;
    n_mis     = 0;
    gate_mode = 0;
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pass", 32'(pass), 32'd0);
    check_eq("rst_obs", 32'(observed), 32'h00);
    check_eq("rst_mis", 32'(mismatch), 32'h00);
    check_eq("rst_in", 32'({in1, in2, in3}), 32'd0);

    // Good gate: full sweep
    kick_start();
    watch(1'b0, 50, d_cyc, d_cnt, s_err);
    check_eq("good_done_cyc", 32'(d_cyc), 32'd41);
    check_eq("good_done_cnt", 32'(d_cnt), 32'd1);
    check_eq("good_seq", 32'(s_err), 32'd0);
    check_eq("good_pass", 32'(pass), 32'd1);
    check_eq("good_obs", 32'(observed), 32'hE9);
    check_eq("good_mis", 32'(mismatch), 32'h00);

    // Stuck-at-0 gate
    gate_mode = 1;
    kick_start();
    watch(1'b0, 50, d_cyc, d_cnt, s_err);
    check_eq("stuck_done_cyc", 32'(d_cyc), 32'd41);
    check_eq("stuck_pass", 32'(pass), 32'd0);
    check_eq("stuck_obs", 32'(observed), 32'h00);
    check_eq("stuck_mis", 32'(mismatch), 32'hE9);

    // Vector 011 inverted
    gate_mode = 2;
    kick_start();
    watch(1'b0, 50, d_cyc, d_cnt, s_err);
    check_eq("inv3_pass", 32'(pass), 32'd0);
    check_eq("inv3_obs", 32'(observed), 32'hE1);
    check_eq("inv3_mis", 32'(mismatch), 32'h08);

    // start re-pulsed mid-sweep is ignored
    gate_mode = 0;
    kick_start();
    watch(1'b1, 50, d_cyc, d_cnt, s_err);
    check_eq("repulse_done_cyc", 32'(d_cyc), 32'd41);
    check_eq("repulse_done_cnt", 32'(d_cnt), 32'd1);
    check_eq("repulse_seq", 32'(s_err), 32'd0);
    check_eq("repulse_pass", 32'(pass), 32'd1);

    // Abort while vector 5 (cycles 26..30) is applied
    kick_start();
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_eq("abort_pre_in", 32'({in1, in2, in3}), 32'd5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_pass", 32'(pass), 32'd0);
    check_eq("abort_mis", 32'(mismatch), 32'h00);
    check_eq("abort_obs", 32'(observed), 32'h09);
    check_eq("abort_in", 32'({in1, in2, in3}), 32'd0);
    d_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) d_cnt++;
    end
    check_eq("abort_no_done", 32'(d_cnt), 32'd0);
    kick_start();
    watch(1'b0, 50, d_cyc, d_cnt, s_err);
    check_eq("post_abort_done_cyc", 32'(d_cyc), 32'd41);
    check_eq("post_abort_pass", 32'(pass), 32'd1);

    // Reset while vector 2 (cycles 11..15) is applied, start held high
    kick_start();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_eq("rst_mid_pre_obs", 32'(observed), 32'h01);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_obs", 32'(observed), 32'h00);
    check_eq("rst_mid_in", 32'({in1, in2, in3}), 32'd0);
    check_eq("rst_mid_pass", 32'(pass), 32'd0);
    check_eq("rst_mid_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    watch(1'b0, 50, d_cyc, d_cnt, s_err);
    check_eq("rst_restart_done_cyc", 32'(d_cyc), 32'd41);
    check_eq("rst_restart_seq", 32'(s_err), 32'd0);
    check_eq("rst_restart_pass", 32'(pass), 32'd1);
    check_eq("rst_restart_obs", 32'(observed), 32'hE9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
